pipeline_result_buffer: RTL and testbench

//  Downstream consumer of the 3-stage 16-bit pipeline datapath. The datapath has no valid or stall,
//  so this block runs a valid shift register alongside it, aligned to the datapath latency.

---
 rtl/pipeline_result_buffer.sv | 103 ++++++++++
 tb/tb_pipeline_result_buffer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_result_buffer.sv
// Result buffer behind a fixed-latency datapath: valid shift register, FWFT FIFO, credit-style src_ready.
// Optional STATS_EN macro builds the push counter and occupancy high-water mark.
module pipeline_result_buffer #(
  parameter int DATA_W   = 16,
  parameter int PIPE_LAT = 3,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [DATA_W-1:0] dp_data,
  input  logic              flush,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic [15:0]       stat_words,
  output logic [AW:0]       stat_hwm
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [PIPE_LAT-1:0] vld_sr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         inflight, count_nxt;
  logic                dp_valid, push, pop;

  assign dp_valid = vld_sr[PIPE_LAT-1];
  assign m_valid  = (count != '0);
  assign m_data   = m_valid ? mem[rd_ptr] : '0;
  assign pop      = m_valid & m_ready;
  assign push     = dp_valid & ((count != FULL) | pop);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_LAT; i++) inflight = inflight + (AW+1)'(vld_sr[i]);
  end

  // Credit counts words already in the datapath; a same-cycle pop is not credited.
  assign src_ready = ({1'b0, count} + {1'b0, inflight}) < {1'b0, FULL};

  always_comb begin
    count_nxt = count;
    if (flush) count_nxt = '0;
    else begin
      case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      vld_sr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      vld_sr[0] <= src_valid;
      for (int i = 1; i < PIPE_LAT; i++) vld_sr[i] <= vld_sr[i-1];
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      if (dp_valid && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= dp_data;
  end

`ifdef STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words <= '0;
      stat_hwm   <= '0;
    end else if (flush) begin
      stat_words <= '0;
      stat_hwm   <= '0;
    end else begin
      if (push && stat_words != 16'hFFFF) stat_words <= stat_words + 1'b1;
      if (count_nxt > stat_hwm) stat_hwm <= count_nxt;
    end
  end
`else
  assign stat_words = '0;
  assign stat_hwm   = '0;
`endif

endmodule

// File: tb/tb_pipeline_result_buffer.sv
// Randomized bench for pipeline_result_buffer against a queue-based model; includes a datapath stub
// f(x) = 8*x + 0x15 delayed 3 cycles, so input 0x0010 yields 0x0095.
module tb_pipeline_result_buffer;
  localparam int DW = 16, LAT = 3, DEPTH = 8, AW = 3;

  logic clk = 0, rst_n = 0;
  logic src_valid = 0, src_ready, flush = 0, m_valid, m_ready = 0, overflow;
  logic [DW-1:0] dp_data, m_data, in_data = '0;
  logic [AW:0] count, stat_hwm;
  logic [15:0] stat_words;
  logic [DW-1:0] dp_pipe [LAT];

  always #5 clk = ~clk;

  pipeline_result_buffer #(.DATA_W(DW), .PIPE_LAT(LAT), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(src_ready),
    .dp_data(dp_data), .flush(flush), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .count(count), .overflow(overflow),
    .stat_words(stat_words), .stat_hwm(stat_hwm));

  function automatic logic [15:0] f(input logic [15:0] x);
    return 16'((x << 3) + 16'h0015);
  endfunction

  always_ff @(posedge clk) begin
    dp_pipe[0] <= f(in_data);
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_data = dp_pipe[LAT-1];

  typedef struct { int due; logic [15:0] v; } pend_t;
  logic [15:0] q[$];
  pend_t pend[$];
  bit ovf;
  int words, hwm, cyc, checks, errors;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit model_ready();
    return (q.size() + pend.size()) < DEPTH;
  endfunction

  task automatic compare_all();
    chk("m_valid", 32'(m_valid), 32'(q.size() > 0));
    chk("m_data", 32'(m_data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
    chk("count", 32'(count), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(ovf));
    chk("src_ready", 32'(src_ready), 32'(model_ready()));
`ifdef STATS_EN
    chk("stat_words", 32'(stat_words), 32'(words));
    chk("stat_hwm", 32'(stat_hwm), 32'(hwm));
`else
    chk("stat_words", 32'(stat_words), 32'h0);
    chk("stat_hwm", 32'(stat_hwm), 32'h0);
`endif
  endtask

  task automatic model_update();
    bit dpv, pop, push;
    logic [15:0] dv;
    dv  = '0;
    dpv = pend.size() > 0 && pend[0].due == cyc;
    pop = q.size() > 0 && m_ready;
    if (flush) begin
      q.delete(); pend.delete(); ovf = 0; words = 0; hwm = 0;
    end else begin
      if (dpv) begin dv = pend[0].v; void'(pend.pop_front()); end
      push = dpv && (q.size() < DEPTH || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(dv);
        if (words < 65535) words++;
      end else if (dpv) ovf = 1;
      if (q.size() > hwm) hwm = q.size();
      if (src_valid) pend.push_back('{cyc + LAT, f(in_data)});
    end
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model, land #1 after the next edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    model_update();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 0; src_valid = 0; flush = 0; m_ready = 0;
    q.delete(); pend.delete(); ovf = 0; words = 0; hwm = 0;
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_m_data", 32'(m_data), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_src_ready", 32'(src_ready), 32'h1);
    rst_n = 1;
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Single word: 0x0010 -> 0x0095, dp at t+3, m_valid at t+4.
    src_valid = 1; in_data = 16'h0010; step();
    src_valid = 0; in_data = 16'h1234; step(); step();
    chk("lat_dp_data", 32'(dp_data), 32'h0095);
    chk("lat_m_valid_early", 32'(m_valid), 32'h0);
    step();
    chk("lat_m_valid", 32'(m_valid), 32'h1);
    chk("lat_m_data", 32'(m_data), 32'h0095);
    chk("lat_count", 32'(count), 32'h1);

    // Credit-respecting fill.
    flush = 1; step(); flush = 0;
    for (int i = 0; i < 20; i++) begin
      src_valid = model_ready(); in_data = 16'($urandom); step();
    end
    src_valid = 0;
    chk("fill_count", 32'(count), 32'h8);
    chk("fill_overflow", 32'(overflow), 32'h0);
    chk("fill_src_ready", 32'(src_ready), 32'h0);

    // Forced overrun.
    flush = 1; step(); flush = 0;
    for (int i = 0; i < 12; i++) begin
      src_valid = 1; in_data = 16'(i + 1); step();
    end
    src_valid = 0;
    for (int i = 0; i < 4; i++) step();
    chk("ovr_count", 32'(count), 32'h8);
    chk("ovr_overflow", 32'(overflow), 32'h1);
    chk("ovr_head", 32'(m_data), 32'(f(16'd1)));

    // Full FIFO: arrival and pop in the same cycle.
    src_valid = 1; in_data = 16'h00AA; step();
    src_valid = 0; step(); step();
    m_ready = 1; step(); m_ready = 0;
    chk("full_pp_count", 32'(count), 32'h8);
    chk("full_pp_head", 32'(m_data), 32'(f(16'd2)));

    // Flush with 5 stored and 2 in flight.
    flush = 1; step(); flush = 0;
    for (int i = 0; i < 5; i++) begin src_valid = 1; in_data = 16'(i + 50); step(); end
    src_valid = 0; step(); step(); step();
    chk("pre_flush_count", 32'(count), 32'h5);
    src_valid = 1; step(); step(); src_valid = 0;
    flush = 1; step(); flush = 0;
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_m_valid", 32'(m_valid), 32'h0);
    chk("flush_overflow", 32'(overflow), 32'h0);
    for (int i = 0; i < 5; i++) step();
    chk("flush_drop", 32'(count), 32'h0);

    // Stream 10 words through with the consumer always ready.
    m_ready = 1;
    for (int i = 0; i < 10; i++) begin src_valid = 1; in_data = 16'($urandom); step(); end
    src_valid = 0;
    for (int i = 0; i < 6; i++) step();
    chk("stream_empty", 32'(count), 32'h0);
`ifdef STATS_EN
    chk("stat_words10", 32'(stat_words), 32'd10);
    chk("stat_hwm1", 32'(stat_hwm), 32'd1);
`endif

    // Random phase: obey or ignore credit in alternating windows, sporadic flush and reset.
    for (int i = 0; i < 3000; i++) begin
      bit obey;
      obey = ((i / 200) % 2) == 0;
      m_ready = ($urandom_range(0, 3) != 0) ? (($urandom_range(0, 1)) != 0) : 1'b0;
      src_valid = obey ? (model_ready() && $urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
      in_data = 16'($urandom);
      flush = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end
    flush = 0; src_valid = 0; m_ready = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
